regfile_op_sequencer: RTL and testbench
=======================================

// Module: regfile_op_sequencer
// PURPOSE
//  Command-driven client of the 16x16 two-read/one-write register file. Drives both read-address
//  ports, samples the two operands, computes a 16-bit ALU result and drives the write port.
//  Executes one command at a time and sits between the command source and the register file.
// PARAMETERS
//  DATA_W  16  register/operand width
//  ADDR_W  4   register address width (2**ADDR_W registers)
// PORTS
//  clk_i        in   1       single clock, all state on posedge
//  rst_i        in   1       synchronous, active-high reset
//  cmd_valid_i  in   1       command present
//  cmd_ready_o  out  1       sequencer can accept a command
//  cmd_op_i     in   3       operation code, see BEHAVIOUR
//  cmd_rd_i     in   ADDR_W  destination register
//  cmd_rs1_i    in   ADDR_W  source register 1
//  cmd_rs2_i    in   ADDR_W  source register 2
//  rd1_addr_o   out  ADDR_W  to register-file read port 1 address
//  rd2_addr_o   out  ADDR_W  to register-file read port 2 address
//  rd1_data_i   in   DATA_W  from register-file read port 1 data (asynchronous read)
//  rd2_data_i   in   DATA_W  from register-file read port 2 data (asynchronous read)
//  wr_en_o      out  1       register-file write enable
//  wr_addr_o    out  ADDR_W  register-file write address
//  wr_data_o    out  DATA_W  register-file write data
//  done_o       out  1       one-cycle pulse when a command retires
// BEHAVIOUR
//  - FSM: IDLE -> READ -> EXEC -> WRITE -> IDLE. One command per 4 cycles.
//  - IDLE: cmd_ready_o=1. On cmd_valid_i&cmd_ready_o, latch op/rd/rs1/rs2 and go to READ.
//  - READ: rd1_addr_o=rs1 and rd2_addr_o=rs2 are registered and stable. This is one full cycle for the async read to settle.
//  - EXEC: sample rd1_data_i/rd2_data_i at the closing edge and register the result. Addresses stay held.
//  - WRITE: wr_en_o=1 for exactly one cycle (0 for NOP). wr_addr_o=rd. wr_data_o=result. done_o=1 this cycle.
//  - cmd_ready_o=0 in READ/EXEC/WRITE. A command held valid in WRITE is accepted in the following IDLE cycle.
//  - Ops (A=rs1 data, B=rs2 data, all modulo 2**DATA_W):
//    000 ADD A+B, 001 SUB A-B, 010 AND, 011 OR, 100 XOR, 101 MOV A, 110 SHL A<<1 (LSB 0),
//    111 NOP (no write, done_o still pulses).
//  - rd may equal rs1/rs2: operands are sampled in EXEC, before the write in WRITE.
//  - Reset (any state, including mid-command): state IDLE. All outputs 0: cmd_ready_o=0 during the reset cycle, then 1.
//    The pending command is dropped and no write is issued.
//  - wr_en_o/done_o are never asserted outside WRITE. Outputs change only on clk_i posedge.
// CONFIGURATION
//  - REGSEQ_FLAGS_EN defined: adds outputs zero_o(1) and carry_o(1), both registered in EXEC and held until the next EXEC.
//    zero_o = (result==0) for every op except NOP.
//    carry_o = carry-out of ADD or borrow of SUB (A<B unsigned), shifted-out MSB for SHL, 0 for other ops.
//    NOP leaves both flags unchanged. Reset value of both flags is 0.
//  - REGSEQ_FLAGS_EN not defined: the flag ports and their logic are absent. Everything else is identical.
// TESTING
//  - Preload r1=0x0005, r2=0x0003. ADD rd=3 rs1=1 rs2=2 -> wr_en_o pulses 3 cycles after accept
//    with wr_addr_o=3 and wr_data_o=0x0008. done_o is high in the same cycle.
//  - r1=0x0003, r2=0x0005, SUB rd=4 -> wr_data_o=0xFFFE. With flags: carry_o=1, zero_o=0.
//    r1=r2, SUB -> 0x0000 with zero_o=1.
//  - NOP -> done_o pulses with wr_en_o=0 throughout. The register file is unchanged.
//  - cmd_valid_i held high with 3 queued commands -> accepts every 4th cycle. Exactly 3 writes occur, in order.
//  - rst_i asserted in EXEC -> no wr_en_o or done_o for that command. All outputs are 0 during reset.
//    cmd_ready_o=1 on the cycle after rst_i falls.
//  - MOV rd=1 rs1=1 with r1=0x8001, then SHL rd=1 rs1=1 -> second write data 0x0002. With flags: carry_o=1.

Source files
------------

// File: rtl/regfile_op_sequencer_if.sv
// Command and register-file port bundle for regfile_op_sequencer.
// Optional flag outputs zero_o/carry_o exist only when REGSEQ_FLAGS_EN is defined.
interface regfile_op_sequencer_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 4
);
   logic              cmd_valid_i;
   logic              cmd_ready_o;
   logic [2:0]        cmd_op_i;
   logic [ADDR_W-1:0] cmd_rd_i;
   logic [ADDR_W-1:0] cmd_rs1_i;
   logic [ADDR_W-1:0] cmd_rs2_i;
   logic [ADDR_W-1:0] rd1_addr_o;
   logic [ADDR_W-1:0] rd2_addr_o;
   logic [DATA_W-1:0] rd1_data_i;
   logic [DATA_W-1:0] rd2_data_i;
   logic              wr_en_o;
   logic [ADDR_W-1:0] wr_addr_o;
   logic [DATA_W-1:0] wr_data_o;
   logic              done_o;
`ifdef REGSEQ_FLAGS_EN
   logic              zero_o;
   logic              carry_o;
`endif

   // Environment side: command source plus the register file's read data.
   modport master (
      output cmd_valid_i, cmd_op_i, cmd_rd_i, cmd_rs1_i, cmd_rs2_i, rd1_data_i, rd2_data_i,
      input  cmd_ready_o, rd1_addr_o, rd2_addr_o, wr_en_o, wr_addr_o, wr_data_o, done_o
`ifdef REGSEQ_FLAGS_EN
      , input zero_o, carry_o
`endif
   );

   modport slave (
      input  cmd_valid_i, cmd_op_i, cmd_rd_i, cmd_rs1_i, cmd_rs2_i, rd1_data_i, rd2_data_i,
      output cmd_ready_o, rd1_addr_o, rd2_addr_o, wr_en_o, wr_addr_o, wr_data_o, done_o
`ifdef REGSEQ_FLAGS_EN
      , output zero_o, carry_o
`endif
   );
endinterface

// File: rtl/regfile_op_sequencer.sv
// Four-phase (IDLE/READ/EXEC/WRITE) ALU sequencer in front of a 2R/1W register file.
// Define REGSEQ_FLAGS_EN to add registered zero_o/carry_o flags.
module regfile_op_sequencer #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   regfile_op_sequencer_if.slave bus
);
   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_EXEC, ST_WRITE} state_e;
   typedef enum logic [2:0] {
      OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
      OP_XOR = 3'b100, OP_MOV = 3'b101, OP_SHL = 3'b110, OP_NOP = 3'b111
   } op_e;

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic              ready_q, ready_d;
   logic [ADDR_W-1:0] rd1_addr_q, rd1_addr_d;
   logic [ADDR_W-1:0] rd2_addr_q, rd2_addr_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              done_q, done_d;
`ifdef REGSEQ_FLAGS_EN
   logic              zero_q, zero_d;
   logic              carry_q, carry_d;
`endif

   // Result in the low DATA_W bits, carry/borrow/shifted-out bit on top.
   logic [DATA_W:0]   alu_w;
   logic [DATA_W-1:0] a, b;

   always_comb begin
      a     = bus.rd1_data_i;
      b     = bus.rd2_data_i;
      alu_w = '0;
      case (op_q)
         OP_ADD:  alu_w = {1'b0, a} + {1'b0, b};
         OP_SUB:  alu_w = {1'b0, a} - {1'b0, b};
         OP_AND:  alu_w = {1'b0, a & b};
         OP_OR:   alu_w = {1'b0, a | b};
         OP_XOR:  alu_w = {1'b0, a ^ b};
         OP_MOV:  alu_w = {1'b0, a};
         OP_SHL:  alu_w = {a, 1'b0};
         default: alu_w = '0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      rd1_addr_d = rd1_addr_q;
      rd2_addr_d = rd2_addr_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      wr_en_d    = 1'b0;
      done_d     = 1'b0;
`ifdef REGSEQ_FLAGS_EN
      zero_d     = zero_q;
      carry_d    = carry_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid_i && ready_q) begin
               op_d       = op_e'(bus.cmd_op_i);
               rd1_addr_d = bus.cmd_rs1_i;
               rd2_addr_d = bus.cmd_rs2_i;
               wr_addr_d  = bus.cmd_rd_i;
               state_d    = ST_READ;
            end
         end
         ST_READ: state_d = ST_EXEC;
         ST_EXEC: begin
            // Outputs are registered, so the WRITE-cycle strobes are set on the EXEC closing edge.
            state_d   = ST_WRITE;
            wr_data_d = alu_w[DATA_W-1:0];
            wr_en_d   = (op_q != OP_NOP);
            done_d    = 1'b1;
`ifdef REGSEQ_FLAGS_EN
            if (op_q != OP_NOP) begin
               zero_d  = (alu_w[DATA_W-1:0] == '0);
               carry_d = alu_w[DATA_W];
            end
`endif
         end
         ST_WRITE: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         op_q       <= OP_NOP;
         ready_q    <= 1'b0;
         rd1_addr_q <= '0;
         rd2_addr_q <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         done_q     <= 1'b0;
`ifdef REGSEQ_FLAGS_EN
         zero_q     <= 1'b0;
         carry_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         ready_q    <= ready_d;
         rd1_addr_q <= rd1_addr_d;
         rd2_addr_q <= rd2_addr_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         done_q     <= done_d;
`ifdef REGSEQ_FLAGS_EN
         zero_q     <= zero_d;
         carry_q    <= carry_d;
`endif
      end
   end

   assign bus.cmd_ready_o = ready_q;
   assign bus.rd1_addr_o  = rd1_addr_q;
   assign bus.rd2_addr_o  = rd2_addr_q;
   assign bus.wr_en_o     = wr_en_q;
   assign bus.wr_addr_o   = wr_addr_q;
   assign bus.wr_data_o   = wr_data_q;
   assign bus.done_o      = done_q;
`ifdef REGSEQ_FLAGS_EN
   assign bus.zero_o      = zero_q;
   assign bus.carry_o     = carry_q;
`endif
endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Directed bench for regfile_op_sequencer with a behavioural 16x16 register file.
// Flag checks are compiled in when REGSEQ_FLAGS_EN is defined.
module tb_regfile_op_sequencer;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   regfile_op_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   regfile_op_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   logic [15:0] rf [16];
   logic        pre_en   = 1'b0;
   logic [3:0]  pre_addr = '0;
   logic [15:0] pre_data = '0;
   int unsigned wcnt = 0;
   int unsigned dcnt = 0;
   logic [3:0]  wlog_addr [64];
   logic [15:0] wlog_data [64];

   assign bus.rd1_data_i = rf[bus.rd1_addr_o];
   assign bus.rd2_data_i = rf[bus.rd2_addr_o];

   always @(posedge clk) begin
      if (bus.wr_en_o) begin
         rf[bus.wr_addr_o]     <= bus.wr_data_o;
         wlog_addr[wcnt[5:0]]  <= bus.wr_addr_o;
         wlog_data[wcnt[5:0]]  <= bus.wr_data_o;
         wcnt                  <= wcnt + 1;
      end else if (pre_en) begin
         rf[pre_addr] <= pre_data;
      end
      if (bus.done_o) dcnt <= dcnt + 1;
   end

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [3:0] a, input logic [15:0] d);
      @(negedge clk);
      pre_en   = 1'b1;
      pre_addr = a;
      pre_data = d;
      @(negedge clk);
      pre_en   = 1'b0;
   endtask

   task automatic check_flags(input string tag, input logic zero, input logic carry);
`ifdef REGSEQ_FLAGS_EN
      check($sformatf("%s_zero", tag), bus.zero_o, zero);
      check($sformatf("%s_carry", tag), bus.carry_o, carry);
`else
      if (zero === 1'bx || carry === 1'bx) $display("flags %s not built", tag);
`endif
   endtask

   task automatic do_cmd(input string tag, input logic [2:0] op, input logic [3:0] rd,
                         input logic [3:0] rs1, input logic [3:0] rs2, input logic [15:0] exp_data);
      int unsigned n = 0;
      int unsigned w0, d0;
      logic        wr = (op != 3'b111);
      @(negedge clk);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_op_i    = op;
      bus.cmd_rd_i    = rd;
      bus.cmd_rs1_i   = rs1;
      bus.cmd_rs2_i   = rs2;
      while (!bus.cmd_ready_o && n < 16) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("%s_accept", tag), n < 16, 1);
      w0 = wcnt;
      d0 = dcnt;
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      check($sformatf("%s_read_rdy", tag), bus.cmd_ready_o, 0);
      check($sformatf("%s_read_a1", tag), bus.rd1_addr_o, rs1);
      check($sformatf("%s_read_a2", tag), bus.rd2_addr_o, rs2);
      check($sformatf("%s_read_we", tag), bus.wr_en_o, 0);
      @(negedge clk);
      check($sformatf("%s_exec_we", tag), bus.wr_en_o, 0);
      check($sformatf("%s_exec_done", tag), bus.done_o, 0);
      check($sformatf("%s_exec_a1", tag), bus.rd1_addr_o, rs1);
      @(negedge clk);
      check($sformatf("%s_wr_we", tag), bus.wr_en_o, wr);
      check($sformatf("%s_wr_done", tag), bus.done_o, 1);
      check($sformatf("%s_wr_rdy", tag), bus.cmd_ready_o, 0);
      if (wr) begin
         check($sformatf("%s_wr_addr", tag), bus.wr_addr_o, rd);
         check($sformatf("%s_wr_data", tag), bus.wr_data_o, exp_data);
      end
      @(negedge clk);
      check($sformatf("%s_idle_rdy", tag), bus.cmd_ready_o, 1);
      check($sformatf("%s_idle_we", tag), bus.wr_en_o, 0);
      check($sformatf("%s_idle_done", tag), bus.done_o, 0);
      check($sformatf("%s_nwrites", tag), wcnt - w0, wr ? 1 : 0);
      check($sformatf("%s_ndone", tag), dcnt - d0, 1);
   endtask

   logic [2:0] bb_op  [3] = '{3'b000, 3'b100, 3'b011};
   logic [3:0] bb_rd  [3] = '{4'd5, 4'd6, 4'd7};
   logic [3:0] bb_rs1 [3] = '{4'd1, 4'd1, 4'd5};
   logic [3:0] bb_rs2 [3] = '{4'd2, 4'd2, 4'd6};
   logic [15:0] bb_exp [3] = '{16'h0008, 16'h0006, 16'h000E};

   initial begin
      int unsigned idx, n, w0, d0;
      int unsigned acc [3];
      bus.cmd_valid_i = 1'b0;
      bus.cmd_op_i    = '0;
      bus.cmd_rd_i    = '0;
      bus.cmd_rs1_i   = '0;
      bus.cmd_rs2_i   = '0;

      for (int i = 0; i < 16; i++) preload(i[3:0], 16'h0000);
      check("rst_ready", bus.cmd_ready_o, 0);
      check("rst_we", bus.wr_en_o, 0);
      check("rst_done", bus.done_o, 0);
      check("rst_a1", bus.rd1_addr_o, 0);
      check("rst_wdata", bus.wr_data_o, 0);
      check_flags("rst", 0, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rel_ready", bus.cmd_ready_o, 1);

      preload(4'd1, 16'h0005);
      preload(4'd2, 16'h0003);
      do_cmd("add", 3'b000, 4'd3, 4'd1, 4'd2, 16'h0008);
      check_flags("add", 0, 0);

      preload(4'd1, 16'h0003);
      preload(4'd2, 16'h0005);
      do_cmd("sub", 3'b001, 4'd4, 4'd1, 4'd2, 16'hFFFE);
      check_flags("sub", 0, 1);
      do_cmd("sub0", 3'b001, 4'd5, 4'd2, 4'd2, 16'h0000);
      check_flags("sub0", 1, 0);
      do_cmd("nop", 3'b111, 4'd6, 4'd1, 4'd2, 16'h0000);
      check_flags("nop", 1, 0);
      do_cmd("and", 3'b010, 4'd6, 4'd1, 4'd2, 16'h0001);
      check_flags("and", 0, 0);
      do_cmd("or", 3'b011, 4'd6, 4'd1, 4'd2, 16'h0007);
      do_cmd("xor", 3'b100, 4'd6, 4'd1, 4'd2, 16'h0006);

      preload(4'd1, 16'hFFFF);
      preload(4'd2, 16'h0001);
      do_cmd("addc", 3'b000, 4'd7, 4'd1, 4'd2, 16'h0000);
      check_flags("addc", 1, 1);

      preload(4'd1, 16'h8001);
      do_cmd("mov", 3'b101, 4'd1, 4'd1, 4'd2, 16'h8001);
      check_flags("mov", 0, 0);
      do_cmd("shl", 3'b110, 4'd1, 4'd1, 4'd2, 16'h0002);
      check_flags("shl", 0, 1);

      // Three commands with valid held high
      preload(4'd1, 16'h0005);
      preload(4'd2, 16'h0003);
      w0  = wcnt;
      idx = 0;
      n   = 0;
      @(negedge clk);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_op_i    = bb_op[0];
      bus.cmd_rd_i    = bb_rd[0];
      bus.cmd_rs1_i   = bb_rs1[0];
      bus.cmd_rs2_i   = bb_rs2[0];
      while (idx < 3 && n < 64) begin
         if (bus.cmd_ready_o) begin
            acc[idx] = n;
            idx++;
            @(negedge clk);
            n++;
            if (idx < 3) begin
               bus.cmd_op_i  = bb_op[idx];
               bus.cmd_rd_i  = bb_rd[idx];
               bus.cmd_rs1_i = bb_rs1[idx];
               bus.cmd_rs2_i = bb_rs2[idx];
            end else begin
               bus.cmd_valid_i = 1'b0;
            end
         end else begin
            @(negedge clk);
            n++;
         end
      end
      bus.cmd_valid_i = 1'b0;
      check("bb_accepts", idx, 3);
      check("bb_gap01", acc[1] - acc[0], 4);
      check("bb_gap12", acc[2] - acc[1], 4);
      n = 0;
      while (wcnt - w0 < 3 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("bb_nwrites", wcnt - w0, 3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("bb_addr%0d", i), wlog_addr[w0 + i], bb_rd[i]);
         check($sformatf("bb_data%0d", i), wlog_data[w0 + i], bb_exp[i]);
      end

      // Reset while the command is in EXEC
      w0 = wcnt;
      d0 = dcnt;
      n  = 0;
      @(negedge clk);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_op_i    = 3'b000;
      bus.cmd_rd_i    = 4'd8;
      bus.cmd_rs1_i   = 4'd1;
      bus.cmd_rs2_i   = 4'd2;
      while (!bus.cmd_ready_o && n < 16) begin
         @(negedge clk);
         n++;
      end
      check("mr_accept", n < 16, 1);
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mr_ready", bus.cmd_ready_o, 0);
      check("mr_we", bus.wr_en_o, 0);
      check("mr_done", bus.done_o, 0);
      check("mr_a1", bus.rd1_addr_o, 0);
      check("mr_a2", bus.rd2_addr_o, 0);
      check("mr_waddr", bus.wr_addr_o, 0);
      check("mr_wdata", bus.wr_data_o, 0);
      check_flags("mr", 0, 0);
      rst = 1'b0;
      @(negedge clk);
      check("mr_rel_ready", bus.cmd_ready_o, 1);
      repeat (4) @(negedge clk);
      check("mr_nwrites", wcnt - w0, 0);
      check("mr_ndone", dcnt - d0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end
endmodule
